// File: rtl/pll_reconfig_ctrl.sv
// PLL dynamic reconfiguration sequencer: serially scans a configuration image into
// the PLL, strobes configupdate, then waits for scandone and relock under a timeout.
module pll_reconfig_ctrl #(
  parameter int CHAIN_LEN    = 144,
  parameter int SCLK_HALF    = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] cfg_word,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 scanclk,
  output logic                 scanclkena,
  output logic                 scandata,
  output logic                 configupdate,
  output logic                 pll_areset,
  input  logic                 scandone,
  input  logic                 locked
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SHIFT     = 3'd1;
  localparam logic [2:0] UPDATE    = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RELOCK    = 3'd4;
  localparam logic [2:0] FIN       = 3'd5;

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(CHAIN_LEN + 1);

  logic [2:0]           state;
  logic [CHAIN_LEN-1:0] sreg;
  logic [HW-1:0]        hcnt;
  logic [BW-1:0]        rcnt;
  logic [31:0]          tcnt;
  logic [1:0]           acnt;
  logic                 aphase;
  logic                 grace;
  logic [1:0]           sd_sync, lk_sync;
  logic                 sd_s, lk_s, tick, expire;

  assign sd_s   = sd_sync[1];
  assign lk_s   = lk_sync[1];
  assign tick   = (hcnt == HW'(SCLK_HALF - 1));
  assign expire = (tcnt >= 32'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_sync <= '0;
      lk_sync <= '0;
    end else begin
      sd_sync <= {sd_sync[0], scandone};
      lk_sync <= {lk_sync[0], locked};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      hcnt         <= '0;
      rcnt         <= '0;
      tcnt         <= '0;
      acnt         <= '0;
      aphase       <= 1'b0;
      grace        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      scanclk      <= 1'b0;
      scanclkena   <= 1'b0;
      scandata     <= 1'b0;
      configupdate <= 1'b0;
      pll_areset   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= SHIFT;
          busy       <= 1'b1;
          scandata   <= cfg_word[CHAIN_LEN-1];
          sreg       <= cfg_word << 1;
          scanclkena <= 1'b1;
          scanclk    <= 1'b0;
          hcnt       <= '0;
          rcnt       <= '0;
          tcnt       <= '0;
          grace      <= 1'b0;
        end
        SHIFT: begin
          if (tick) begin
            hcnt    <= '0;
            scanclk <= ~scanclk;
            if (!scanclk) rcnt <= rcnt + 1'b1;
            else if (rcnt == BW'(CHAIN_LEN)) begin
              // falling edge after the last rising edge opens the update window
              state        <= UPDATE;
              scanclkena   <= 1'b0;
              configupdate <= 1'b1;
            end else begin
              scandata <= sreg[CHAIN_LEN-1];
              sreg     <= sreg << 1;
            end
          end else hcnt <= hcnt + 1'b1;
        end
        UPDATE: begin
          if (tick) begin
            hcnt    <= '0;
            scanclk <= ~scanclk;
            if (scanclk) begin
              state        <= WAIT_DONE;
              configupdate <= 1'b0;
              tcnt         <= '0;
            end
          end else hcnt <= hcnt + 1'b1;
        end
        WAIT_DONE: begin
          tcnt <= tcnt + 32'd1;
          if (sd_s) begin
            state      <= RELOCK;
            pll_areset <= 1'b1;
            acnt       <= '0;
            aphase     <= 1'b1;
            // scandone on the expiry cycle still gets one chance to relock
            grace      <= expire;
          end else if (expire) begin
            state <= FIN;
            err   <= 1'b1;
          end
        end
        RELOCK: begin
          tcnt <= tcnt + 32'd1;
          if (aphase && expire && !grace) begin
            state      <= FIN;
            err        <= 1'b1;
            pll_areset <= 1'b0;
            aphase     <= 1'b0;
          end else if (aphase) begin
            acnt <= acnt + 2'd1;
            if (acnt == 2'd3) begin
              pll_areset <= 1'b0;
              aphase     <= 1'b0;
            end
          end else if (lk_s) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (expire) begin
            state <= FIN;
            err   <= 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          busy       <= 1'b0;
          pll_areset <= 1'b0;
          aphase     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
